// File: rtl/regfile_dump_if.sv
// regfile_dump_if: byte stream valid/ready bus from the dump engine to the debug serializer
interface regfile_dump_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  modport master(output out_data, out_valid, input out_ready);
  modport slave(input out_data, out_valid, output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: walks the register file through one async read port and streams each entry as header + LSB-first bytes
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG = 15,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  regfile_dump_if.master    o
);
  localparam int NB = DATA_W / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [ADDR_W-1:0] FIRST = FIRST_REG[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LAST = LAST_REG[ADDR_W-1:0];
  localparam logic [BW-1:0] BLAST = BW'(NB - 1);
  typedef enum logic [2:0] {IDLE, LOAD, HDR, BYTE, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] idx;
  logic [BW-1:0] bcnt;
  logic [DATA_W-1:0] word;
  logic hs;
  assign hs = o.out_valid & o.out_ready;
  // word is shifted down as bytes go out, so word[7:0] is always the next byte
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state <= IDLE;
      idx <= '0;
      bcnt <= '0;
      word <= '0;
      rd_addr <= '0;
      o.out_data <= '0;
      o.out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx <= FIRST;
          rd_addr <= FIRST;
          busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          word <= rd_data;
          o.out_valid <= 1'b1;
          o.out_data <= {HDR_TAG, 4'(idx)};
          state <= HDR;
        end
        HDR: if (hs) begin
          bcnt <= '0;
          o.out_data <= word[7:0];
          word <= word >> 8;
          state <= BYTE;
        end
        BYTE: if (hs) begin
          if (bcnt != BLAST) begin
            bcnt <= bcnt + 1'b1;
            o.out_data <= word[7:0];
            word <= word >> 8;
          end else begin
            o.out_valid <= 1'b0;
            o.out_data <= '0;
            idx <= idx + 1'b1;
            rd_addr <= idx == LAST ? '0 : idx + 1'b1;
            done <= idx == LAST;
            state <= idx == LAST ? DONE : LOAD;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed dumps covering streaming, back-pressure, snapshot timing, ignored start, abort and reset
module tb_regfile_dump;
  logic clk = 1'b0;
  logic rst, start, abort;
  logic [3:0] rd_addr;
  logic [31:0] rd_data;
  logic busy, done;
  logic [31:0] rf[16];
  logic [31:0] expw[16];
  int total = 0;
  int bad = 0;
  regfile_dump_if bus();
  regfile_dump dut(.clk(clk), .rst(rst), .start(start), .abort(abort), .rd_addr(rd_addr),
                   .rd_data(rd_data), .busy(busy), .done(done), .o(bus));
  always #5 clk = ~clk;
  assign rd_data = rf[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // mode 0: ready=1, 1: ready 1-on/2-off, 2: regfile writes during r5,
  // 3: stray start during r4, 4: abort at r6 byte 2, 5: rst at r8 header with ready=0
  task automatic dump(input int mode);
    int got = 0;
    int cyc = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [7:0] pd = '0;
    logic [7:0] want;
    logic fired = 1'b0;
    logic fin = 1'b0;
    start = 1'b1;
    while (!fin && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      rst = 1'b0;
      bus.out_ready = mode == 1 ? (cyc % 3 == 1) : 1'b1;
      if (cyc == 1) begin
        chk("busy_rise", busy, 1);
        chk("rd_addr_first", rd_addr, 0);
      end
      if (fired && mode >= 4) begin
        chk($sformatf("m%0d_valid_off", mode), bus.out_valid, 0);
        chk($sformatf("m%0d_busy_off", mode), busy, 0);
        chk($sformatf("m%0d_no_done", mode), done, 0);
        if (mode == 5) begin
          chk("rst_rd_addr", rd_addr, 0);
          chk("rst_out_data", bus.out_data, 0);
        end
        fin = 1'b1;
      end else begin
        if (pv && !pr) begin
          chk($sformatf("hold_valid%0d", got), bus.out_valid, 1);
          chk($sformatf("hold_data%0d", got), bus.out_data, pd);
        end
        if (done) begin
          chk($sformatf("done_count_m%0d", mode), got, 80);
          chk("done_rd_addr", rd_addr, 0);
          if (mode == 0) chk("done_cycle", cyc, 97);
          fin = 1'b1;
        end else if (mode == 4 && got == 33 && bus.out_valid) begin
          abort = 1'b1;
          fired = 1'b1;
        end else if (mode == 5 && got == 40 && bus.out_valid) begin
          rst = 1'b1;
          bus.out_ready = 1'b0;
          fired = 1'b1;
        end else if (bus.out_valid && bus.out_ready) begin
          want = got % 5 == 0 ? {4'hA, 4'(got / 5)} : expw[got / 5][8 * (got % 5 - 1) +: 8];
          chk($sformatf("m%0d_byte%0d", mode, got), bus.out_data, want);
          got++;
          if (mode == 2 && got == 27 && !fired) begin
            rf[9] = 32'hDEAD0000;
            rf[2] = 32'h000000FF;
            fired = 1'b1;
          end
          if (mode == 3 && got == 21 && !fired) begin
            start = 1'b1;
            fired = 1'b1;
          end
        end
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = bus.out_data;
    end
    if (!fin) chk($sformatf("timeout_m%0d", mode), cyc, 0);
    if (mode <= 3) begin
      @(negedge clk);
      chk($sformatf("done_pulse_m%0d", mode), done, 0);
      chk($sformatf("busy_after_m%0d", mode), busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    rf[1] = 32'd7;
    rf[3] = 32'h12345678;
    rf[15] = 32'd4;
    for (int i = 0; i < 16; i++) expw[i] = rf[i];
    dump(0);
    dump(1);
    rf[2] = 32'h00000022;
    expw[2] = 32'h00000022;
    expw[9] = 32'hDEAD0000;
    dump(2);
    expw[2] = 32'h000000FF;
    dump(3);
    dump(4);
    dump(0);
    dump(5);
    dump(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
